bloque_generador: RTL and testbench

BLOQUE_GENERADOR -- requirements
Module: bloque_generador

---
 rtl/bloque_generador_pkg.sv | 16 +
 rtl/bloque_generador_if.sv | 17 +
 rtl/bloque_generador_nonce_contador.sv | 40 ++++
 rtl/bloque_generador.sv | 101 ++++++++++
 tb/tb_bloque_generador.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bloque_generador_pkg.sv
// Shared types and default sizing for the block generator.
// The optional statistics counter is enabled with BLOQUE_GEN_STATS_EN.
package bloque_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int          DEF_HDR_W   = 96;
  localparam int          DEF_NONCE_W = 32;
  localparam int unsigned DEF_STRIDE  = 1;

endpackage

// File: rtl/bloque_generador_if.sv
// Output block stream of the generator.
// Handshake: a block transfers on a rising edge where out_valid and out_ready are both 1;
// while out_valid=1 and out_ready=0 the master holds bloque_out and out_last stable.
interface bloque_generador_if
  import bloque_gen_pkg::*;
#(
  parameter int HDR_W   = DEF_HDR_W,
  parameter int NONCE_W = DEF_NONCE_W
);
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic [HDR_W+NONCE_W-1:0] bloque_out;

  modport master (output out_valid, output bloque_out, output out_last, input out_ready);
  modport slave  (input out_valid, input bloque_out, input out_last, output out_ready);
endinterface

// File: rtl/bloque_generador_nonce_contador.sv
// Nonce register with stride increment and end-of-sweep detection.
module nonce_contador #(
  parameter int          NONCE_W = 32,
  parameter int unsigned STRIDE  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [NONCE_W-1:0] i_nonce_start,
  input  logic [NONCE_W-1:0] i_nonce_end,
  input  logic               i_advance,
  output logic [NONCE_W-1:0] o_nonce,
  output logic               o_last
);

  localparam logic [NONCE_W:0] STRIDE_X = (NONCE_W+1)'(STRIDE);

  logic [NONCE_W-1:0] r_nonce;
  logic [NONCE_W-1:0] r_end;
  logic [NONCE_W:0]   w_diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nonce <= '0;
      r_end   <= '0;
    end else if (i_load) begin
      r_nonce <= i_nonce_start;
      r_end   <= i_nonce_end;
    end else if (i_advance) begin
      r_nonce <= r_nonce + STRIDE_X[NONCE_W-1:0];
    end
  end

  // A borrow out of the extended subtraction means the nonce is already past the end
  // (empty range), which also has to be treated as the final block.
  assign w_diff  = {1'b0, r_end} - {1'b0, r_nonce};
  assign o_last  = w_diff[NONCE_W] | (w_diff < STRIDE_X);
  assign o_nonce = r_nonce;

endmodule

// File: rtl/bloque_generador.sv
// Emits {header, nonce} blocks over a nonce sweep, with abort and backpressure.
// Optional handshake counter output blocks_sent when BLOQUE_GEN_STATS_EN is defined.
module bloque_generador
  import bloque_gen_pkg::*;
#(
  parameter int          HDR_W   = DEF_HDR_W,
  parameter int          NONCE_W = DEF_NONCE_W,
  parameter int unsigned STRIDE  = DEF_STRIDE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [HDR_W-1:0]   header,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic               stop,
  bloque_generador_if.master out_if,
  output logic               busy,
  output logic               done,
  output state_t             dbg_state
`ifdef BLOQUE_GEN_STATS_EN
  ,
  output logic [31:0]        blocks_sent
`endif
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [HDR_W-1:0]   r_header;
  logic               w_accept;
  logic               w_valid;
  logic               w_hs;
  logic               w_last;
  logic               w_advance;
  logic [NONCE_W-1:0] w_nonce;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_valid   = (r_state == ST_RUN);
  assign w_hs      = w_valid && out_if.out_ready;
  assign w_advance = w_hs && !w_last;

  nonce_contador #(
    .NONCE_W (NONCE_W),
    .STRIDE  (STRIDE)
  ) u_nonce_contador (
    .clk           (clk),
    .reset         (reset),
    .i_load        (w_accept),
    .i_nonce_start (nonce_start),
    .i_nonce_end   (nonce_end),
    .i_advance     (w_advance),
    .o_nonce       (w_nonce),
    .o_last        (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_header <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_header <= header;
    end
  end

  // stop only matters in RUN; a handshake in the same cycle still delivers its block
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_RUN;
      ST_RUN:  if ((w_hs && w_last) || stop) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign out_if.out_valid  = w_valid;
  assign out_if.out_last   = w_valid && w_last;
  assign out_if.bloque_out = {r_header, w_nonce};
  assign busy              = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign done              = (r_state == ST_DONE);
  assign dbg_state         = r_state;

`ifdef BLOQUE_GEN_STATS_EN
  logic [31:0] r_blocks_sent;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blocks_sent <= '0;
    end else if (w_accept) begin
      r_blocks_sent <= '0;
    end else if (w_hs && (r_blocks_sent != 32'hFFFF_FFFF)) begin
      r_blocks_sent <= r_blocks_sent + 32'd1;
    end
  end

  assign blocks_sent = r_blocks_sent;
`endif

endmodule

// File: tb/tb_bloque_generador.sv
// Bench for bloque_generador: a default-stride instance and a STRIDE=3 instance share stimulus.
module tb_bloque_generador;
  import bloque_gen_pkg::*;

  localparam int HW = 96;
  localparam int NW = 32;
  localparam int BW = HW + NW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stop, ready, sel;
  logic [HW-1:0] header;
  logic [NW-1:0] nonce_start, nonce_end;
  logic          a_start, b_start;
  logic          a_busy, a_done, b_busy, b_done;
  state_t        a_state, b_state;

  logic          m_valid, m_last, m_busy, m_done;
  logic [BW-1:0] m_blk;
  state_t        m_state;

  logic [NW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  bloque_generador_if #(.HDR_W(HW), .NONCE_W(NW)) a_if ();
  bloque_generador_if #(.HDR_W(HW), .NONCE_W(NW)) b_if ();

`ifdef BLOQUE_GEN_STATS_EN
  logic [31:0] a_blocks, b_blocks, m_blocks;
  assign m_blocks = sel ? b_blocks : a_blocks;
`endif

  always #5 clk = ~clk;

  assign a_start      = start & ~sel;
  assign b_start      = start & sel;
  assign a_if.out_ready = ready;
  assign b_if.out_ready = ready;

  assign m_valid = sel ? b_if.out_valid  : a_if.out_valid;
  assign m_last  = sel ? b_if.out_last   : a_if.out_last;
  assign m_blk   = sel ? b_if.bloque_out : a_if.bloque_out;
  assign m_busy  = sel ? b_busy : a_busy;
  assign m_done  = sel ? b_done : a_done;
  assign m_state = sel ? b_state : a_state;

  bloque_generador #(.HDR_W(HW), .NONCE_W(NW), .STRIDE(1)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .header(header),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .stop(stop),
    .out_if(a_if.master), .busy(a_busy), .done(a_done), .dbg_state(a_state)
`ifdef BLOQUE_GEN_STATS_EN
    , .blocks_sent(a_blocks)
`endif
  );

  bloque_generador #(.HDR_W(HW), .NONCE_W(NW), .STRIDE(3)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .header(header),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .stop(stop),
    .out_if(b_if.master), .busy(b_busy), .done(b_done), .dbg_state(b_state)
`ifdef BLOQUE_GEN_STATS_EN
    , .blocks_sent(b_blocks)
`endif
  );

  // Reference: every nonce start, start+stride, ... not exceeding end; an empty range yields start only.
  function automatic void build_exp(input logic [NW-1:0] ns, input logic [NW-1:0] ne, input int unsigned stride);
    exp_q.delete();
    if (ne < ns) exp_q.push_back(ns);
    else for (longint n = longint'(ns); n <= longint'(ne); n += longint'(stride)) exp_q.push_back(n[NW-1:0]);
  endfunction

  function automatic logic [HW-1:0] rand_hdr();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic run_sweep(input bit s, input logic [HW-1:0] hdr, input logic [NW-1:0] ns,
                           input logic [NW-1:0] ne, input int rdy_pct, input longint hold_nonce);
    int delivered = 0;
    int cyc = 0;
    int hold_left = 0;
    bit fin = 0;
    bit held = 0;
    bit stall = 0;
    bit exp_last;
    logic prev_last = 1'b0;
    logic [BW-1:0] prev_blk = '0;
    logic [NW-1:0] exp_n;
    build_exp(ns, ne, s ? 3 : 1);
    @(negedge clk);
    sel = s; header = hdr; nonce_start = ns; nonce_end = ne; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b1 || m_state !== ST_LOAD) begin
      n_fail++;
      $display("FAIL sweep_load: valid=%b busy=%b state=%0d want 0 1 %0d", m_valid, m_busy, m_state, ST_LOAD);
    end
    while (!fin && cyc < 500) begin
      @(negedge clk);
      cyc++;
      n_checks++;
      if (m_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_valid: out_valid=%b want 1 at cycle %0d", m_valid, cyc);
        fin = 1;
      end else begin
        if (stall) begin
          n_checks++;
          if (m_blk !== prev_blk || m_last !== prev_last) begin
            n_fail++;
            $display("FAIL stall_hold: blk=%h last=%b want %h %b", m_blk, m_last, prev_blk, prev_last);
          end
        end
        if (hold_left > 0) begin
          ready = 1'b0; hold_left--;
        end else if (!held && longint'(m_blk[NW-1:0]) == hold_nonce) begin
          held = 1; hold_left = 3; ready = 1'b0;
        end else begin
          ready = ($urandom_range(99) < rdy_pct);
        end
        if (ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_block: got %h want no further block", m_blk);
            fin = 1;
          end else begin
            exp_n = exp_q.pop_front();
            exp_last = (exp_q.size() == 0);
            if (m_blk !== {hdr, exp_n}) begin
              n_fail++;
              $display("FAIL block: got %h want %h", m_blk, {hdr, exp_n});
            end
            n_checks++;
            if (m_last !== exp_last) begin
              n_fail++;
              $display("FAIL last: nonce %h out_last=%b want %b", exp_n, m_last, exp_last);
            end
            delivered++;
            fin = m_last || exp_last;
          end
        end
        stall = !ready; prev_blk = m_blk; prev_last = m_last;
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL sweep_timeout: no final block after %0d cycles, want final block", cyc);
    end
    if (hold_nonce >= 0) begin
      n_checks++;
      if (!held) begin
        n_fail++;
        $display("FAIL hold_reached: nonce %0d never shown, want it shown", hold_nonce);
      end
    end
    @(negedge clk);
    ready = 1'b0;
    n_checks++;
    if (m_done !== 1'b1 || m_valid !== 1'b0 || m_busy !== 1'b0 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b valid=%b busy=%b last=%b want 1 0 0 0", m_done, m_valid, m_busy, m_last);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_blocks: %0d left undelivered, want 0", exp_q.size());
    end
`ifdef BLOQUE_GEN_STATS_EN
    n_checks++;
    if (m_blocks !== 32'(delivered)) begin
      n_fail++;
      $display("FAIL blocks_sent: got %0d want %0d", m_blocks, delivered);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (m_done !== 1'b0 || m_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL done_width: done=%b state=%0d want 0 %0d", m_done, m_state, ST_IDLE);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (a_if.out_valid !== 1'b0 || a_if.out_last !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 ||
        a_if.bloque_out !== '0 || a_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_a: valid=%b last=%b busy=%b done=%b blk=%h want all 0", a_if.out_valid,
               a_if.out_last, a_busy, a_done, a_if.bloque_out);
    end
    n_checks++;
    if (b_if.out_valid !== 1'b0 || b_if.out_last !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 ||
        b_if.bloque_out !== '0 || b_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_b: valid=%b last=%b busy=%b done=%b blk=%h want all 0", b_if.out_valid,
               b_if.out_last, b_busy, b_done, b_if.bloque_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_sweep(1'b0, rand_hdr(), 32'd5, 32'd8, 100, -1);
  endtask

  task automatic test_stride3();
    run_sweep(1'b1, rand_hdr(), 32'd0, 32'd7, 100, -1);
    run_sweep(1'b1, rand_hdr(), 32'd0, 32'd7, 60, -1);
  endtask

  task automatic test_backpressure();
    run_sweep(1'b0, rand_hdr(), 32'd0, 32'd10, 100, 6);
  endtask

  task automatic test_stop(input bit rdy_at_stop);
    int delivered = 0;
    int cyc = 0;
    bit found = 0;
    @(negedge clk);
    sel = 1'b0; header = rand_hdr(); nonce_start = 32'd0; nonce_end = 32'd100; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!found && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (m_valid && m_blk[NW-1:0] == 32'd2) found = 1;
      else if (m_valid) delivered++;
    end
    stop = 1'b1; ready = rdy_at_stop;
    if (rdy_at_stop) delivered++;
    @(negedge clk);
    stop = 1'b0; ready = 1'b0;
    n_checks++;
    if (!found || m_valid !== 1'b0 || m_done !== 1'b1 || m_state !== ST_DONE) begin
      n_fail++;
      $display("FAIL stop_abort: found=%b valid=%b done=%b state=%0d want 1 0 1 %0d", found, m_valid, m_done, m_state, ST_DONE);
    end
    n_checks++;
    if (delivered != (rdy_at_stop ? 3 : 2)) begin
      n_fail++;
      $display("FAIL stop_delivered: got %0d blocks want %0d", delivered, rdy_at_stop ? 3 : 2);
    end
`ifdef BLOQUE_GEN_STATS_EN
    n_checks++;
    if (m_blocks !== 32'(rdy_at_stop ? 3 : 2)) begin
      n_fail++;
      $display("FAIL stop_blocks_sent: got %0d want %0d", m_blocks, rdy_at_stop ? 3 : 2);
    end
`endif
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b0 || m_done !== 1'b0 || m_state !== ST_IDLE) begin
        n_fail++;
        $display("FAIL stop_idle: valid=%b done=%b state=%0d want 0 0 %0d", m_valid, m_done, m_state, ST_IDLE);
      end
    end
  endtask

  task automatic test_wrap_start_ignored();
    logic [HW-1:0] hdr;
    hdr = rand_hdr();
    @(negedge clk);
    sel = 1'b0; header = hdr; nonce_start = 32'hFFFF_FFFE; nonce_end = 32'h0000_0001; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b1; nonce_start = 32'd5; header = rand_hdr();
    repeat (3) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_blk !== {hdr, 32'hFFFF_FFFE} || m_last !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_block: valid=%b blk=%h last=%b want 1 %h 1", m_valid, m_blk, m_last, {hdr, 32'hFFFF_FFFE});
      end
      @(negedge clk);
    end
    ready = 1'b1; start = 1'b0;
    n_checks++;
    if (m_blk !== {hdr, 32'hFFFF_FFFE} || m_last !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_hs: blk=%h last=%b want %h 1", m_blk, m_last, {hdr, 32'hFFFF_FFFE});
    end
    @(negedge clk);
    ready = 1'b0;
    n_checks++;
    if (m_done !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done: done=%b valid=%b want 1 0", m_done, m_valid);
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_state !== ST_IDLE) begin
        n_fail++;
        $display("FAIL wrap_idle: busy=%b valid=%b state=%0d want 0 0 %0d", m_busy, m_valid, m_state, ST_IDLE);
      end
    end
  endtask

  task automatic test_random();
    logic [NW-1:0] ns, ne;
    run_sweep(1'b1, rand_hdr(), 32'hFFFF_FFF0, 32'hFFFF_FFFF, 80, -1);
    run_sweep(1'b0, rand_hdr(), 32'hFFFF_FFFC, 32'hFFFF_FFFF, 80, -1);
    for (int i = 0; i < 12; i++) begin
      ns = $urandom;
      if ($urandom_range(3) == 0) ne = ns - 32'($urandom_range(1, 5));
      else ne = ns + 32'($urandom_range(0, 20));
      run_sweep(1'($urandom_range(1)), rand_hdr(), ns, ne, int'($urandom_range(40, 100)), -1);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    sel = 1'b0; header = rand_hdr(); nonce_start = 32'd10; nonce_end = 32'd50; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 ||
        m_blk !== '0 || m_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b last=%b busy=%b done=%b blk=%h want all 0", m_valid, m_last, m_busy, m_done, m_blk);
    end
`ifdef BLOQUE_GEN_STATS_EN
    n_checks++;
    if (m_blocks !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_blocks_sent: got %0d want 0", m_blocks);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if (m_done !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done: done=%b valid=%b want 0 0", m_done, m_valid);
      end
    end
    ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b0; sel = 1'b0;
    header = '0; nonce_start = '0; nonce_end = '0;
    test_reset();
    test_basic();
    test_stride3();
    test_backpressure();
    test_stop(1'b0);
    test_stop(1'b1);
    test_wrap_start_ignored();
    test_random();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
